// File: rtl/mem_port_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_pkg
// Brief    : Shared definitions for the memory-port sequencer: state encoding
//            and the opcode field positions decoded from IR.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_pkg;

   // Sequencer states, 2-bit encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   // IR field positions; the control FSM decodes the same fields
   localparam int INSTR_LSB = 0;
   localparam int INSTR_W   = 4;
   localparam int REGS_LSB  = 4;
   localparam int REGS_W    = 4;

   // Wait counter width, sized for TIMEOUT values 1..255
   localparam int WAIT_W    = 8;

endpackage
`default_nettype wire

// File: rtl/mem_port_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_if
// Brief    : Handshaked memory bus between the sequencer (master) and the
//            external memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface
`default_nettype wire

// File: rtl/mem_port.sv
`default_nettype none
// ============================================================================
// Module   : mem_port
// Brief    : Turns single-cycle MemRead/MemWrite strobes into a req/ack memory
//            transaction, owns IR and MDR, and stalls the FSM while waiting.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port
   import mem_port_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                MemRead,
   input  logic                MemWrite,
   input  logic                IRload,
   input  logic                MDRload,
   input  logic [ADDR_W-1:0]   addr_in,
   input  logic [DATA_W-1:0]   wdata_in,
   mem_port_if.master          mem,
   output logic                stall,
   output logic [DATA_W-1:0]   ir,
   output logic [INSTR_W-1:0]  instr,
   output logic [REGS_W-1:0]   instr_regs,
   output logic [DATA_W-1:0]   mdr,
   output logic                err
);

   // Last REQ cycle index before abort (counter holds k-1 in REQ cycle k)
   localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(TIMEOUT - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                we_q, we_d;
   logic                req_q, req_d;
   logic                irld_q, irld_d;
   logic                mdrld_q, mdrld_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic [DATA_W-1:0]   mdr_q, mdr_d;
   logic                err_q, err_d;
   logic [WAIT_W-1:0]   cnt_q, cnt_d;
   logic                strobe;

   assign strobe = MemRead | MemWrite;

   // Next-state and datapath update: launch from IDLE, wait/abort in REQ
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      req_d   = req_q;
      irld_d  = irld_q;
      mdrld_d = mdrld_q;
      ir_d    = ir_q;
      mdr_d   = mdr_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (strobe) begin
               addr_d  = addr_in;
               wdata_d = wdata_in;
               we_d    = MemWrite;
               irld_d  = IRload;
               mdrld_d = MDRload;
               req_d   = 1'b1;
               cnt_d   = '0;
               state_d = REQ;
               // Conflicting strobes: the write wins and is flagged
               if (MemRead && MemWrite) err_d = 1'b1;
            end
         end
         REQ: begin
            // An ack in the final wait cycle beats the timeout
            if (mem.mem_ack) begin
               if (!we_q) begin
                  if (irld_q)  ir_d  = mem.mem_rdata;
                  if (mdrld_q) mdr_d = mem.mem_rdata;
               end
               req_d   = 1'b0;
               state_d = DONE;
            end else if (cnt_q == TO_LAST) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // Strobes here are leftovers of the completed access; ignore them
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Transaction, IR/MDR and error registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         req_q   <= 1'b0;
         irld_q  <= 1'b0;
         mdrld_q <= 1'b0;
         ir_q    <= '0;
         mdr_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         req_q   <= req_d;
         irld_q  <= irld_d;
         mdrld_q <= mdrld_d;
         ir_q    <= ir_d;
         mdr_q   <= mdr_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Stall asserts combinationally in the same cycle the strobe appears
   assign stall = ((state_q == IDLE) && strobe) || (state_q == REQ);

   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

   assign ir         = ir_q;
   assign mdr        = mdr_q;
   assign err        = err_q;
   assign instr      = ir_q[INSTR_LSB +: INSTR_W];
   assign instr_regs = ir_q[REGS_LSB +: REGS_W];

endmodule
`default_nettype wire

// File: tb/tb_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port
// Brief    : Self-checking bench for mem_port: random and directed accesses,
//            a scripted memory responder, and a scoreboard monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port;
   import mem_port_pkg::*;

   localparam int DW = 8;
   localparam int AW = 8;
   localparam int TO = 3;

   logic          clock   = 1'b0;
   logic          reset_n = 1'b0;
   logic          MemRead = 1'b0, MemWrite = 1'b0, IRload = 1'b0, MDRload = 1'b0;
   logic [AW-1:0] addr_in  = '0;
   logic [DW-1:0] wdata_in = '0;
   logic          stall, err;
   logic [DW-1:0] ir, mdr;
   logic [3:0]    instr, instr_regs;

   mem_port_if #(.DATA_W(DW), .ADDR_W(AW)) mif ();

   mem_port #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .IRload     (IRload),
      .MDRload    (MDRload),
      .addr_in    (addr_in),
      .wdata_in   (wdata_in),
      .mem        (mif),
      .stall      (stall),
      .ir         (ir),
      .instr      (instr),
      .instr_regs (instr_regs),
      .mdr        (mdr),
      .err        (err)
   );

   always #5 clock = ~clock;

   typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } req_t;
   typedef struct { logic [DW-1:0] ir; logic [DW-1:0] mdr; logic err; int ncyc; } res_t;
   typedef struct { int k; logic [DW-1:0] rdata; } plan_t;

   req_t  req_q[$];
   res_t  res_q[$];
   plan_t plan_q[$];

   // Architectural model of the visible registers
   logic [DW-1:0] m_ir = '0, m_mdr = '0;
   logic          m_err = 1'b0;

   logic          force_ack = 1'b0;
   logic [DW-1:0] force_rdata = '0;

   int vec  = 0;
   int errs = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      vec++;
      errs++;
      $display("FAIL %s: got an event with no expected entry, expected none", name);
   endtask

   // Memory responder: acks in the planned REQ cycle, junk data otherwise
   initial begin : responder
      int    cnt;
      bit    active;
      plan_t p;
      cnt = 0; active = 0; p.k = 0; p.rdata = '0;
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = '0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            active = 0; cnt = 0;
            mif.mem_ack = 1'b0;
         end else if (mif.mem_req) begin
            if (!active) begin
               active = 1; cnt = 0;
               if (plan_q.size() > 0) p = plan_q.pop_front();
               else p.k = 1000;
            end
            cnt++;
            if (cnt == p.k) begin
               mif.mem_ack   = 1'b1;
               mif.mem_rdata = p.rdata;
            end else begin
               mif.mem_ack   = 1'b0;
               mif.mem_rdata = DW'($urandom);
            end
         end else begin
            active = 0;
            mif.mem_ack   = force_ack;
            mif.mem_rdata = force_ack ? force_rdata : DW'($urandom);
         end
      end
   end

   // Scoreboard monitor: request fields every REQ cycle, results in DONE
   initial begin : monitor
      req_t cur;
      res_t r;
      bit   cur_ok, prev;
      int   ncyc;
      cur_ok = 0; prev = 0; ncyc = 0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            prev = 0;
         end else begin
            if (mif.mem_req) begin
               if (!prev) begin
                  ncyc = 0;
                  if (req_q.size() == 0) begin
                     fail_now("spurious_req");
                     cur_ok = 0;
                  end else begin
                     cur = req_q.pop_front();
                     cur_ok = 1;
                  end
               end
               ncyc++;
               if (cur_ok) begin
                  chk("req_we",    32'(mif.mem_we),    32'(cur.we));
                  chk("req_addr",  32'(mif.mem_addr),  32'(cur.addr));
                  chk("req_wdata", 32'(mif.mem_wdata), 32'(cur.wdata));
               end
               chk("req_stall", 32'(stall), 32'h1);
            end else if (prev) begin
               if (res_q.size() == 0) begin
                  fail_now("unexpected_done");
               end else begin
                  r = res_q.pop_front();
                  chk("done_ir",         32'(ir),         32'(r.ir));
                  chk("done_mdr",        32'(mdr),        32'(r.mdr));
                  chk("done_err",        32'(err),        32'(r.err));
                  chk("done_instr",      32'(instr),      32'(r.ir[3:0]));
                  chk("done_instr_regs", 32'(instr_regs), 32'(r.ir[7:4]));
                  chk("done_req_cycles", 32'(ncyc),       32'(r.ncyc));
                  chk("done_stall",      32'(stall),      32'h0);
               end
            end
            prev = mif.mem_req;
         end
      end
   end

   // One access: compute expected outcome from the rules, then drive the strobe
   task automatic do_txn(input bit rd, input bit wr, input bit irl, input bit mdrl,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int k, input logic [DW-1:0] rdat);
      req_t  rq;
      res_t  rs;
      plan_t pl;
      bit    tmo, done;
      int    n;
      tmo = (k > TO);
      rq.we = wr; rq.addr = a; rq.wdata = wd;
      if (tmo || (rd && wr)) m_err = 1'b1;
      if (!tmo && !wr) begin
         if (irl)  m_ir  = rdat;
         if (mdrl) m_mdr = rdat;
      end
      rs.ir = m_ir; rs.mdr = m_mdr; rs.err = m_err; rs.ncyc = tmo ? TO : k;
      pl.k = k; pl.rdata = rdat;
      req_q.push_back(rq);
      res_q.push_back(rs);
      plan_q.push_back(pl);
      MemRead = rd; MemWrite = wr; IRload = irl; MDRload = mdrl;
      addr_in = a; wdata_in = wd;
      n = 0; done = 0;
      for (int c = 0; c < 4 * TO + 20; c++) begin
         @(negedge clock);
         if (stall) n++;
         else begin
            done = 1;
            break;
         end
      end
      chk("stall_release", 32'(done), 32'h1);
      chk("stall_cycles",  32'(n),    32'(1 + rs.ncyc));
      // Strobes stay high through DONE, dropped after it
      @(posedge clock); #1;
      MemRead = 0; MemWrite = 0;
      IRload = 1'($urandom); MDRload = 1'($urandom);
      addr_in = AW'($urandom); wdata_in = DW'($urandom);
   endtask

   task automatic rand_txn(input bit allow_bad);
      int op, k;
      op = allow_bad ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 1));
      k  = allow_bad ? int'($urandom_range(1, TO + 2)) : int'($urandom_range(1, TO));
      do_txn(op != 1, op != 0, 1'($urandom), 1'($urandom),
             AW'($urandom), DW'($urandom), k, DW'($urandom));
      repeat ($urandom_range(0, 2)) begin
         @(posedge clock); #1;
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_mem_req"},    32'(mif.mem_req),   32'h0);
      chk({tag, "_mem_we"},     32'(mif.mem_we),    32'h0);
      chk({tag, "_mem_addr"},   32'(mif.mem_addr),  32'h0);
      chk({tag, "_mem_wdata"},  32'(mif.mem_wdata), 32'h0);
      chk({tag, "_ir"},         32'(ir),            32'h0);
      chk({tag, "_mdr"},        32'(mdr),           32'h0);
      chk({tag, "_instr"},      32'(instr),         32'h0);
      chk({tag, "_instr_regs"}, 32'(instr_regs),    32'h0);
      chk({tag, "_err"},        32'(err),           32'h0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      req_t  rq;
      plan_t pl;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk_reset_state("reset");
      chk("reset_stall", 32'(stall), 32'h0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;

      // Fetch: ack in REQ cycle 2
      do_txn(1, 0, 1, 0, 8'h10, 8'h00, 2, 8'h41);
      chk("fetch_instr",      32'(instr),      32'h1);
      chk("fetch_instr_regs", 32'(instr_regs), 32'h4);
      chk("fetch_mdr",        32'(mdr),        32'h0);
      // Load: ack in REQ cycle 1
      do_txn(1, 0, 0, 1, 8'h20, 8'h00, 1, 8'hA5);
      chk("load_mdr", 32'(mdr), 32'hA5);
      chk("load_ir",  32'(ir),  32'h41);
      // Store: returned data must not reach IR/MDR
      do_txn(0, 1, 1, 1, 8'h30, 8'h5C, TO, 8'h99);
      chk("store_ir",  32'(ir),  32'h41);
      chk("store_mdr", 32'(mdr), 32'hA5);

      repeat (40) rand_txn(0);
      chk("clean_err", 32'(err), 32'h0);

      // Timeout: no ack at all
      do_txn(1, 0, 1, 1, 8'h40, 8'h00, TO + 1, 8'h77);
      chk("timeout_err", 32'(err), 32'h1);
      chk("timeout_ir",  32'(ir),  32'(m_ir));
      chk("timeout_mdr", 32'(mdr), 32'(m_mdr));

      // Stray ack in IDLE with both destination flags raised
      IRload = 1; MDRload = 1; force_rdata = 8'hEE; force_ack = 1;
      @(posedge clock); #1;
      force_ack = 0;
      @(negedge clock);
      chk("stray_ir",      32'(ir),          32'(m_ir));
      chk("stray_mdr",     32'(mdr),         32'(m_mdr));
      chk("stray_mem_req", 32'(mif.mem_req), 32'h0);
      @(posedge clock); #1;

      // Conflicting strobes: write issued, flagged
      do_txn(1, 1, 1, 1, 8'h50, 8'h3C, 1, 8'hEE);
      chk("conflict_err", 32'(err), 32'h1);

      // Reset in the middle of REQ
      rq.we = 0; rq.addr = 8'h60; rq.wdata = 8'h11;
      pl.k = 1000; pl.rdata = '0;
      req_q.push_back(rq);
      plan_q.push_back(pl);
      MemRead = 1; MemWrite = 0; IRload = 1; MDRload = 0;
      addr_in = 8'h60; wdata_in = 8'h11;
      @(posedge clock);
      @(posedge clock); #3;
      reset_n = 1'b0;
      #1;
      chk_reset_state("midreset");
      MemRead = 0; IRload = 0;
      #1;
      chk("midreset_stall", 32'(stall), 32'h0);
      repeat (2) @(posedge clock);
      #1;
      plan_q.delete(); req_q.delete(); res_q.delete();
      m_ir = '0; m_mdr = '0; m_err = 1'b0;
      reset_n = 1'b1;
      @(posedge clock); #1;
      do_txn(1, 0, 1, 0, 8'h70, 8'h00, 2, 8'hC3);
      chk("post_reset_ir",  32'(ir),  32'hC3);
      chk("post_reset_err", 32'(err), 32'h0);

      repeat (30) rand_txn(1);

      repeat (5) @(posedge clock);
      chk("req_queue_drained", 32'(req_q.size()), 32'h0);
      chk("res_queue_drained", 32'(res_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_port.md
# mem_port

Memory-port sequencer between the multicycle control FSM and an external handshaked memory. It converts the FSM's single-cycle MemRead/MemWrite strobes into a req/ack transaction and owns the IR and MDR registers. It presents the IR opcode fields to the FSM and raises `stall` to freeze the FSM and datapath until the access completes. Memory latency is therefore decoupled from the FSM's fixed cycle schedule.

## Interface
- `DATA_W`, 8: data and IR/MDR width.
- `ADDR_W`, 8: address width.
- `TIMEOUT`, 15: maximum number of REQ cycles without `mem_ack` before the access is aborted. Range 1..255.
- `clock` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `MemRead` in 1: read strobe from the FSM.
- `MemWrite` in 1: write strobe from the FSM.
- `IRload` in 1: route read data to IR.
- `MDRload` in 1: route read data to MDR.
- `addr_in` in ADDR_W: address, already selected by AddrSel.
- `wdata_in` in DATA_W: store data.
- `mem_req` out 1: request to memory.
- `mem_we` out 1: 1 = write.
- `mem_addr` out ADDR_W: registered address.
- `mem_wdata` out DATA_W: registered write data.
- `mem_rdata` in DATA_W: read data, valid while `mem_ack` = 1.
- `mem_ack` in 1: one-cycle completion pulse.
- `stall` out 1: freeze enable for the FSM and datapath.
- `ir` out DATA_W: instruction register.
- `instr` out 4: equal to `ir[3:0]`.
- `instr_regs` out 4: equal to `ir[7:4]`.
- `mdr` out DATA_W: memory data register.
- `err` out 1: sticky error flag.

## Operation
- States: IDLE, REQ, DONE. Encode them in 2 bits.
- IDLE, with `MemRead` or `MemWrite` = 1:
  - Capture `addr_in` and `wdata_in`.
  - Capture `mem_we` = `MemWrite`.
  - Capture the destination flags `IRload` and `MDRload`.
  - Go to REQ.
- IDLE, with no strobe: stay in IDLE.
- REQ:
  - `mem_req` = 1. `mem_addr`, `mem_we` and `mem_wdata` stay stable.
  - Wait counter increments every cycle without `mem_ack`.
  - On `mem_ack` = 1, for a read:
    - `ir` ← `mem_rdata` if the captured IRload = 1.
    - `mdr` ← `mem_rdata` if the captured MDRload = 1.
    - Both registers load if both flags are set.
    - Go to DONE.
  - On `mem_ack` = 1 for a write: no register update. Go to DONE.
  - Counter reaches TIMEOUT with no ack:
    - Drop `mem_req`.
    - Set `err`. IR and MDR are unchanged.
    - Go to DONE.
- DONE:
  - Lasts one cycle with `stall` = 0, so the FSM advances.
  - Strobes seen in DONE are ignored, because they are still the previous state's controls.
  - Always go to IDLE next.
- `MemRead` and `MemWrite` both high in IDLE: the write is performed and `err` is set.
- `mem_ack` outside REQ: ignored.
- `err` is cleared only by reset.

## Timing
- `stall` is combinational. It equals (IDLE and (MemRead or MemWrite)) or REQ. It is asserted in the same cycle the FSM raises the strobe.
- Access latency:
  - Minimum: 3 cycles from strobe to the FSM advancing (IDLE-launch, REQ with ack, DONE).
  - General case: 2 + k cycles for an ack in REQ cycle k.
- `mem_req` is registered: high from the first REQ cycle through the ack cycle inclusive.
- IR and MDR update on the clock edge that ends the ack cycle, so they are visible in DONE.
- Timeout: abort at the end of REQ cycle TIMEOUT. An ack arriving in that same cycle wins; no error is raised.
- Reset values:
  - State = IDLE.
  - `mem_req` = 0, `mem_we` = 0.
  - `mem_addr` = 0, `mem_wdata` = 0.
  - `ir` = 0, `mdr` = 0 (so `instr` = 0, `instr_regs` = 0).
  - `err` = 0.
  - `stall` = 0 while no strobe is present.
- Reset mid-access: the transaction is abandoned immediately and `mem_req` drops asynchronously. Memory must tolerate a withdrawn request.

## Structure
- Shared package `mem_port_pkg` holds:
  - the state encoding constants IDLE = 0, REQ = 1, DONE = 2;
  - the `instr` and `instr_regs` field positions, so decode matches the FSM.
- No sub-modules. The wait counter is an 8-bit local register (width fixed by the TIMEOUT range).

## Test plan
- Fetch:
  - Stimulus: IRload = MemRead = 1, `addr_in` = 0x10, ack on REQ cycle 2 with rdata = 0x41.
  - Response: `stall` high for 3 cycles, `ir` = 0x41, `instr` = 1, `instr_regs` = 4, `mdr` unchanged.
- Load:
  - Stimulus: MDRload = MemRead = 1, `addr_in` = 0x20, ack on REQ cycle 1 with rdata = 0xA5.
  - Response: `mdr` = 0xA5, `ir` unchanged, `mem_we` = 0 throughout.
- Store:
  - Stimulus: MemWrite = 1, `addr_in` = 0x30, `wdata_in` = 0x5C.
  - Response: `mem_we` = 1, `mem_addr` = 0x30, `mem_wdata` = 0x5C held until ack; no IR/MDR change.
- Timeout:
  - Stimulus: TIMEOUT = 3, no ack.
  - Response: `mem_req` high for exactly 3 cycles, `err` = 1, `ir` and `mdr` unchanged, `stall` released at DONE.
- Strobe held through DONE:
  - Stimulus: MemRead held high through DONE.
  - Response: no second `mem_req`.
- Conflict and spurious ack:
  - Stimulus: a stray `mem_ack` pulse in IDLE, then MemRead and MemWrite asserted together.
  - Response: the stray ack is ignored; the write is issued; `err` = 1.
- Reset in REQ:
  - Stimulus: assert `reset_n` = 0 mid-wait.
  - Response: `mem_req` = 0 immediately, all outputs at reset values, and the next strobe starts a clean access.
